xpb_accum_seq: RTL and testbench
================================

XPB_ACCUM_SEQ -- requirements
Module: xpb_accum_seq

Interface
REQ-001 Parameter NUM_DIGITS, default 8: 5-bit digits reduced per job.
REQ-002 Parameter DIGIT_W, default 5: bits per digit and per table address.
REQ-003 Parameter XPB_W, default 1024: width of one table entry.
REQ-004 Derived constant IDX_W = $clog2(NUM_DIGITS); ACC_W = XPB_W + IDX_W.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  job offered.
REQ-008 in_ready  output  1  job accepted when in_valid && in_ready at an edge.
REQ-009 in_digits  input  NUM_DIGITS*DIGIT_W  digit k at bits [k*DIGIT_W +: DIGIT_W].
REQ-010 lut_req  output  1  table lookup issued this cycle.
REQ-011 lut_pos  output  IDX_W  digit position k, selecting the per-position table.
REQ-012 lut_addr  output  DIGIT_W  digit value used as table address.
REQ-013 lut_data  input  XPB_W  entry, valid the cycle after the matching lut_req (1-cycle registered latency).
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  result consumed when out_valid && out_ready at an edge.
REQ-016 out_data  output  ACC_W  sum of all looked-up entries, no modular wrap.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE; in_ready = 1 only in IDLE.
REQ-018 On accept at edge E0: in_digits captured into a digit register, accumulator cleared, position counter set to 0, go to RUN.
REQ-019 In RUN, each cycle: lut_req=1, lut_pos=k, lut_addr=digit k; k increments; after k=NUM_DIGITS-1 go to DRAIN.
REQ-020 A data-valid flag delayed one cycle from lut_req; when set, accumulator += zero-extended lut_data at that edge.
REQ-021 DRAIN lasts one cycle, absorbing the final entry, then goes to DONE.
REQ-022 Result latency: out_valid rises at edge E0+NUM_DIGITS+1 (edge E0+9 for default).
REQ-023 In DONE, out_valid=1 and out_data held stable until out_ready; on handshake go to IDLE.
REQ-024 in_ready is low in DONE; a new job cannot be accepted in the same edge as the result handshake.
REQ-025 lut_req=0 in IDLE, DRAIN and DONE; lut_pos/lut_addr are don't-care when lut_req=0.
REQ-026 in_digits changes after accept have no effect on the running job.
REQ-027 ACC_W is sufficient for NUM_DIGITS entries of maximum value; no overflow condition exists.

Reset
REQ-028 Reset asserted at any time, including mid-RUN, forces state IDLE immediately.
REQ-029 Reset values: in_ready=1 after release, lut_req=0, out_valid=0, out_data=0, counter=0, data-valid flag=0.
REQ-030 An entry returned on lut_data in the cycle after reset release is ignored.

Configuration
REQ-031 Macro XPB_SKIP_ZERO_EN, when defined: digits equal to 0 are not issued; RUN issues only the nonzero digits in ascending position order, one per cycle.
REQ-032 With XPB_SKIP_ZERO_EN, N = nonzero digit count: if N>0, out_valid rises at edge E0+N+1; if N=0, IDLE goes directly to DONE and out_valid=1 with out_data=0 at edge E0+1.
REQ-033 Without XPB_SKIP_ZERO_EN, all NUM_DIGITS positions are issued (zero digits included), with the fixed latency of REQ-022.

Structure
REQ-034 Package xpb_pkg holds XPB_W, DIGIT_W, the state enum and the ACC_W computation function.
REQ-035 Sub-module xpb_digit_sel: combinational next-position selector (priority encoder over remaining nonzero mask under XPB_SKIP_ZERO_EN, plain increment otherwise).

Verification
REQ-036 No macro, digit0=5'h01, others 0, LUT model returns 1024'h1 -> lut_req high exactly 8 cycles; out_data=8 at edge E0+9.
REQ-037 No macro, all digits 5'h1F, LUT model returns 2^1023 -> out_data = 8*2^1023 = 2^1026, MSB of ACC_W set, no truncation.
REQ-038 out_ready held low 5 cycles in DONE -> out_data stable, out_valid high, in_ready low throughout; handshake returns to IDLE one edge later.
REQ-039 Reset pulsed at the 4th RUN cycle -> lut_req and out_valid are 0 immediately; a following job with digit0=5'h02 gives correct sum with no residue from the aborted job.
REQ-040 XPB_SKIP_ZERO_EN, only digits 3 and 6 nonzero -> lut_req exactly 2 cycles with lut_pos 3 then 6; out_valid at E0+3; all-zero job -> out_valid at E0+1, out_data=0.

Source files
------------

// File: rtl/xpb_pkg.sv
// rtl/xpb_pkg.sv - shared constants, FSM state type and accumulator width helper for xpb_accum_seq
package xpb_pkg;

  localparam int XPB_W   = 1024;
  localparam int DIGIT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Accumulator needs log2(entry count) guard bits above one entry.
  function automatic int calc_acc_w(input int xpb_w, input int num_digits);
    return xpb_w + $clog2(num_digits);
  endfunction

endpackage

// File: rtl/xpb_digit_sel.sv
// rtl/xpb_digit_sel.sv - next digit position selector (macro XPB_SKIP_ZERO_EN selects nonzero-only mode)
module xpb_digit_sel #(
  parameter  int NUM_DIGITS = 8,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
`ifdef XPB_SKIP_ZERO_EN
  input  logic [NUM_DIGITS-1:0] i_mask,
`else
  input  logic [IDX_W-1:0]      i_pos,
`endif
  output logic [IDX_W-1:0]      o_next_pos,
  output logic                  o_last
);

`ifdef XPB_SKIP_ZERO_EN
  // Lowest set bit of the remaining-nonzero mask; an empty mask means nothing left to issue.
  always_comb begin
    o_next_pos = '0;
    o_last     = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (i_mask[k]) begin
        o_next_pos = IDX_W'(k);
        o_last     = 1'b0;
      end
    end
  end
`else
  // Every position is visited in order; the last one is NUM_DIGITS-1.
  always_comb begin
    o_next_pos = i_pos + 1'b1;
    o_last     = (i_pos == IDX_W'(NUM_DIGITS - 1));
  end
`endif

endmodule

// File: rtl/xpb_accum_seq.sv
// rtl/xpb_accum_seq.sv - digit-indexed table lookup accumulator (optional macro XPB_SKIP_ZERO_EN)
module xpb_accum_seq #(
  parameter  int NUM_DIGITS = 8,
  parameter  int DIGIT_W    = xpb_pkg::DIGIT_W,
  parameter  int XPB_W      = xpb_pkg::XPB_W,
  localparam int IDX_W      = $clog2(NUM_DIGITS),
  localparam int ACC_W      = xpb_pkg::calc_acc_w(XPB_W, NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] in_digits,
  output logic                          lut_req,
  output logic [IDX_W-1:0]              lut_pos,
  output logic [DIGIT_W-1:0]            lut_addr,
  input  logic [XPB_W-1:0]              lut_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data
);

  import xpb_pkg::*;

  state_t                        r_state;
  state_t                        w_next_state;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_digits;
  logic [IDX_W-1:0]              r_pos;
  logic [IDX_W-1:0]              w_next_pos;
  logic [ACC_W-1:0]              r_acc;
  logic                          r_dv;
  logic                          w_last;
  logic                          w_accept;

  assign w_accept = in_valid && (r_state == IDLE);
  assign out_data = r_acc;

`ifdef XPB_SKIP_ZERO_EN
  logic [NUM_DIGITS-1:0] r_mask;
  logic [NUM_DIGITS-1:0] w_in_mask;
  logic [NUM_DIGITS-1:0] w_sel_mask;
  logic [NUM_DIGITS-1:0] w_rest_mask;

  // One bit per incoming digit that is nonzero.
  always_comb begin
    w_in_mask = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_in_mask[k] = |in_digits[k*DIGIT_W +: DIGIT_W];
    end
  end

  // At accept the selector looks at the fresh job; while running, at what is still pending.
  assign w_sel_mask  = (r_state == IDLE) ? w_in_mask : r_mask;
  assign w_rest_mask = w_sel_mask & ~(NUM_DIGITS'(1) << w_next_pos);

  xpb_digit_sel #(.NUM_DIGITS(NUM_DIGITS)) u_sel (
    .i_mask     (w_sel_mask),
    .o_next_pos (w_next_pos),
    .o_last     (w_last)
  );
`else
  xpb_digit_sel #(.NUM_DIGITS(NUM_DIGITS)) u_sel (
    .i_pos      (r_pos),
    .o_next_pos (w_next_pos),
    .o_last     (w_last)
  );
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and handshake/lookup outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    lut_req      = 1'b0;
    out_valid    = 1'b0;
    lut_pos      = r_pos;
    lut_addr     = r_digits[int'(r_pos)*DIGIT_W +: DIGIT_W];
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef XPB_SKIP_ZERO_EN
          // An all-zero job still passes through DRAIN so its result lands one edge after accept.
          w_next_state = w_last ? DRAIN : RUN;
`else
          w_next_state = RUN;
`endif
        end
      end
      RUN: begin
        lut_req = 1'b1;
        if (w_last) w_next_state = DRAIN;
      end
      DRAIN: w_next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Digit capture, position stepping, and accumulation of entries one cycle behind their request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits <= '0;
      r_pos    <= '0;
      r_acc    <= '0;
      r_dv     <= 1'b0;
`ifdef XPB_SKIP_ZERO_EN
      r_mask   <= '0;
`endif
    end else begin
      r_dv <= (r_state == RUN);
      if (w_accept) begin
        r_digits <= in_digits;
        r_acc    <= '0;
`ifdef XPB_SKIP_ZERO_EN
        r_pos    <= w_next_pos;
        r_mask   <= w_rest_mask;
`else
        r_pos    <= '0;
`endif
      end else begin
        if (r_dv) r_acc <= r_acc + ACC_W'(lut_data);
        if (r_state == RUN) begin
          r_pos  <= w_next_pos;
`ifdef XPB_SKIP_ZERO_EN
          r_mask <= w_rest_mask;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_xpb_accum_seq.sv
// tb/tb_xpb_accum_seq.sv - directed self-checking bench for xpb_accum_seq
module tb_xpb_accum_seq;

  localparam int ND = 8;
  localparam int DW = 5;
  localparam int XW = 1024;
  localparam int IW = 3;
  localparam int AW = 1027;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [ND*DW-1:0] in_digits;
  logic            lut_req;
  logic [IW-1:0]   lut_pos;
  logic [DW-1:0]   lut_addr;
  logic [XW-1:0]   lut_data;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_data;

  int tests  = 0;
  int failed = 0;
  int lut_mode = 0;

  int n_lat;
  int n_req;
  logic [IW-1:0] pos_log [2];
  logic [AW-1:0] held;
  logic [AW-1:0] big_exp;

  xpb_accum_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digits (in_digits),
    .lut_req   (lut_req),
    .lut_pos   (lut_pos),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [XW-1:0] lut_model(input int mode, input logic [IW-1:0] pos,
                                              input logic [DW-1:0] addr);
    logic [XW-1:0] v;
    v = '0;
    case (mode)
      0:       v[0] = 1'b1;
      1:       v[XW-1] = 1'b1;
      default: v = XW'({pos, addr});
    endcase
    return v;
  endfunction

  // Registered table: one-cycle latency, garbage whenever no lookup was issued.
  always @(posedge clk) begin
    if (lut_req) lut_data <= lut_model(lut_mode, lut_pos, lut_addr);
    else         lut_data <= {32{32'hDEADBEEF}};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept a job at edge E0, scramble in_digits, then run until out_valid or budget.
  task automatic run_job(input logic [ND*DW-1:0] d);
    @(negedge clk);
    in_valid  = 1'b1;
    in_digits = d;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_digits = 40'h5A_A5_C3_3C_96;
    n_lat = 0;
    n_req = 0;
    while (!out_valid && n_lat < 40) begin
      if (lut_req) begin
        if (n_req < 2) pos_log[n_req] = lut_pos;
        n_req++;
      end
      @(posedge clk);
      #1;
      n_lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_ovalid_after_hs"}, 64'(out_valid), 64'd0);
    check({tag, "_iready_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_digits = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_lut_req",   64'(lut_req),   64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data == '0), 64'd1);

    // digit0 = 1, table returns 1 for every lookup
    lut_mode = 0;
    run_job({5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01});
`ifdef XPB_SKIP_ZERO_EN
    check("one_lat",  64'(n_lat), 64'd2);
    check("one_reqs", 64'(n_req), 64'd1);
    check("one_sum",  out_data[63:0], 64'd1);
`else
    check("one_lat",  64'(n_lat), 64'd9);
    check("one_reqs", 64'(n_req), 64'd8);
    check("one_sum",  out_data[63:0], 64'd8);
`endif
    check("one_in_ready_done", 64'(in_ready), 64'd0);
    handshake("one");

    // all digits 1F, table returns 2^1023: sum 2^1026 fills the top bit
    lut_mode = 1;
    run_job({8{5'h1F}});
    big_exp = '0;
    big_exp[AW-1] = 1'b1;
    check("big_lat",   64'(n_lat), 64'd9);
    check("big_msb",   64'(out_data[AW-1]), 64'd1);
    check("big_exact", 64'(out_data === big_exp), 64'd1);
    handshake("big");

    // mixed digits with position-dependent entries {pos,addr}
    lut_mode = 2;
    run_job({5'h01, 5'h10, 5'h00, 5'h02, 5'h1F, 5'h07, 5'h00, 5'h03});
`ifdef XPB_SKIP_ZERO_EN
    check("mix_lat",  64'(n_lat), 64'd7);
    check("mix_reqs", 64'(n_req), 64'd6);
    check("mix_sum",  out_data[63:0], 64'd764);
`else
    check("mix_lat",  64'(n_lat), 64'd9);
    check("mix_reqs", 64'(n_req), 64'd8);
    check("mix_sum",  out_data[63:0], 64'd956);
`endif
    check("mix_upper", 64'(|out_data[AW-1:64]), 64'd0);

    // result held while out_ready stays low
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_data",     64'(out_data === held), 64'd1);
      check("hold_ovalid",   64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    handshake("mix");

    // reset during the 4th RUN cycle aborts the job
    lut_mode = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_digits = {8{5'h1F}};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort_req_before", 64'(lut_req), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_lut_req",   64'(lut_req),   64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle_data", 64'(out_data == '0), 64'd1);

    lut_mode = 2;
    run_job({5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h02});
`ifdef XPB_SKIP_ZERO_EN
    check("post_lat", 64'(n_lat), 64'd2);
    check("post_sum", out_data[63:0], 64'd2);
`else
    check("post_lat", 64'(n_lat), 64'd9);
    check("post_sum", out_data[63:0], 64'd898);
`endif
    handshake("post");

`ifdef XPB_SKIP_ZERO_EN
    // only digits 3 and 6 nonzero
    run_job({5'h00, 5'h09, 5'h00, 5'h00, 5'h05, 5'h00, 5'h00, 5'h00});
    check("skip_lat",  64'(n_lat), 64'd3);
    check("skip_reqs", 64'(n_req), 64'd2);
    check("skip_pos0", 64'(pos_log[0]), 64'd3);
    check("skip_pos1", 64'(pos_log[1]), 64'd6);
    check("skip_sum",  out_data[63:0], 64'd302);
    handshake("skip");

    // all-zero job
    run_job('0);
    check("zero_lat",  64'(n_lat), 64'd1);
    check("zero_reqs", 64'(n_req), 64'd0);
    check("zero_sum",  64'(out_data == '0), 64'd1);
    handshake("zero");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
